// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and direction indices for the traffic controllers
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } ped_state_t;

  localparam int N_DIRS = 4;

  // Bit positions of the crosswalk directions in btn_in / pending / ped_dir
  localparam int DIR_MN = 0;
  localparam int DIR_MS = 1;
  localparam int DIR_LE = 2;
  localparam int DIR_LW = 3;

endpackage

// File: rtl/ped_debounce.sv
// rtl/ped_debounce.sv - one button: 2-flop synchronizer plus optional debounce filter
// Build option: PED_DEBOUNCE_EN compiles in the filter; otherwise level follows the synchronizer.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   btn    in  raw asynchronous button
//   level  out synchronized (and, when enabled, debounced) button level
module ped_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("ped_debounce: DEBOUNCE_CYCLES out of range 2..255");
  end

  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

`ifdef PED_DEBOUNCE_EN
  localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] stable_cnt;
  logic       filt_level;

  // The counter tracks how many consecutive samples disagree with the
  // accepted level; the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      filt_level <= 1'b0;
    end else if (sync_2 != filt_level) begin
      if (stable_cnt == LAST_COUNT) begin
        stable_cnt <= '0;
        filt_level <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  assign level = filt_level;
`else
  assign level = sync_2;
`endif

endmodule

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian button front end with request/ack/done handshake
// Build option: PED_DEBOUNCE_EN enables the per-button debounce filter.
// Ports:
//   clk       in  system clock
//   rst_a     in  asynchronous active-high reset
//   btn_in    in  [3:0] raw buttons (MN, MS, LE, LW)
//   ped_req   out request to the light sequencer (level)
//   ped_dir   out [3:0] directions covered by the current request / walk
//   ped_ack   in  sequencer accepted the request (pulse)
//   ped_done  in  walk phase finished (pulse)
//   pending   out [3:0] latched presses not yet served
//   urgent    out request has waited MAX_WAIT cycles
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_WAIT        = 64
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic [N_DIRS-1:0] btn_in,
  output logic              ped_req,
  output logic [N_DIRS-1:0] ped_dir,
  input  logic              ped_ack,
  input  logic              ped_done,
  output logic [N_DIRS-1:0] pending,
  output logic              urgent
);

  if (MAX_WAIT < 1 || MAX_WAIT > 65535) begin : g_bad_param
    $error("ped_request_ctrl: MAX_WAIT out of range 1..65535");
  end

  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  logic [N_DIRS-1:0] btn_level;
  logic [N_DIRS-1:0] btn_level_d;
  logic [N_DIRS-1:0] btn_rise;

  for (genvar i = 0; i < N_DIRS; i++) begin : g_btn
    ped_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst_a),
      .btn  (btn_in[i]),
      .level(btn_level[i])
    );
  end

  // Previous level resets to 0, so a button held through reset release
  // is seen as a fresh press once its filtered level rises.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      btn_level_d <= '0;
    end else begin
      btn_level_d <= btn_level;
    end
  end

  assign btn_rise = btn_level & ~btn_level_d;

  ped_state_t        state;
  logic [N_DIRS-1:0] served;
  logic [15:0]       wait_cnt;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state    <= IDLE;
      pending  <= '0;
      served   <= '0;
      wait_cnt <= '0;
      ped_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pending <= pending | btn_rise;
          if (pending != '0) begin
            state   <= REQ;
            ped_req <= 1'b1;
          end
        end

        REQ: begin
          pending <= pending | btn_rise;
          if (ped_ack) begin
            // Presses landing in the ack cycle ride along with this walk
            served   <= pending | btn_rise;
            wait_cnt <= '0;
            state    <= SERVE;
            ped_req  <= 1'b0;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        SERVE: begin
          // Presses on directions already walking are dropped
          if (ped_done) begin
            pending <= (pending | (btn_rise & ~served)) & ~served;
            state   <= IDLE;
          end else begin
            pending <= pending | (btn_rise & ~served);
          end
        end

        default: begin
          state   <= IDLE;
          ped_req <= 1'b0;
        end
      endcase
    end
  end

  // REQ shows the live pending set so late presses join the request
  always_comb begin
    ped_dir = '0;
    if (state == REQ) begin
      ped_dir = pending;
    end else if (state == SERVE) begin
      ped_dir = served;
    end
  end

  assign urgent = (wait_cnt == WAIT_LIMIT);

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - directed self-checking bench for ped_request_ctrl
module tb_ped_request_ctrl;
  import traffic_pkg::*;

  localparam int DEB  = 16;
  localparam int MAXW = 64;
`ifdef PED_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_a;
  logic [3:0] btn_in;
  logic       ped_req;
  logic [3:0] ped_dir;
  logic       ped_ack;
  logic       ped_done;
  logic [3:0] pending;
  logic       urgent;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_WAIT       (MAXW)
  ) dut (
    .clk     (clk),
    .rst_a   (rst_a),
    .btn_in  (btn_in),
    .ped_req (ped_req),
    .ped_dir (ped_dir),
    .ped_ack (ped_ack),
    .ped_done(ped_done),
    .pending (pending),
    .urgent  (urgent)
  );

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    ped_ack = 1'b1;
    step(1);
    ped_ack = 1'b0;
  endtask

  task automatic pulse_done();
    ped_done = 1'b1;
    step(1);
    ped_done = 1'b0;
  endtask

  localparam logic [3:0] B_MN = 4'(1 << DIR_MN);
  localparam logic [3:0] B_MS = 4'(1 << DIR_MS);
  localparam logic [3:0] B_LE = 4'(1 << DIR_LE);
  localparam logic [3:0] B_LW = 4'(1 << DIR_LW);

  initial begin
    rst_a    = 1'b1;
    btn_in   = 4'b0000;
    ped_ack  = 1'b0;
    ped_done = 1'b0;
    step(2);
    chk("rst_req", 16'(ped_req), 16'h0);
    chk("rst_dir", 16'(ped_dir), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    chk("rst_urgent", 16'(urgent), 16'h0);
    rst_a = 1'b0;

    // Single press on Local East
    btn_in = B_LE;
    step(LAT - 1);
    chk("single_pend_early", 16'(pending), 16'h0);
    step(1);
    chk("single_pend", 16'(pending), 16'h4);
    chk("single_req_early", 16'(ped_req), 16'h0);
    step(1);
    chk("single_req", 16'(ped_req), 16'h1);
    chk("single_dir", 16'(ped_dir), 16'h4);
    btn_in = 4'b0000;
    pulse_ack();
    chk("single_serve_req", 16'(ped_req), 16'h0);
    chk("single_serve_dir", 16'(ped_dir), 16'h4);
    chk("single_serve_pend", 16'(pending), 16'h4);
    pulse_done();
    chk("single_done_pend", 16'(pending), 16'h0);
    chk("single_done_req", 16'(ped_req), 16'h0);
    step(LAT + 2);
    chk("single_release_pend", 16'(pending), 16'h0);

    // Short glitch on Main North
    btn_in = B_MN;
    step(10);
    btn_in = 4'b0000;
    step(LAT + 5);
`ifdef PED_DEBOUNCE_EN
    chk("glitch_pend", 16'(pending), 16'h0);
    chk("glitch_req", 16'(ped_req), 16'h0);
`else
    chk("glitch_pend_nodeb", 16'(pending), 16'h1);
    chk("glitch_req_nodeb", 16'(ped_req), 16'h1);
    pulse_ack();
    pulse_done();
    chk("glitch_cleared", 16'(pending), 16'h0);
    step(2);
`endif

    // Join in REQ, drop a served press, keep an unserved one
    btn_in = B_MN;
    step(LAT + 1);
    chk("join_req", 16'(ped_req), 16'h1);
    chk("join_dir_n", 16'(ped_dir), 16'h1);
    btn_in = B_MN | B_LE;
    step(LAT);
    chk("join_dir_ne", 16'(ped_dir), 16'h5);
    btn_in = 4'b0000;
    pulse_ack();
    chk("join_serve_dir", 16'(ped_dir), 16'h5);
    step(LAT + 2);
    btn_in = B_MN;
    step(LAT + 1);
    chk("drop_pend", 16'(pending), 16'h5);
    chk("drop_req", 16'(ped_req), 16'h0);
    btn_in = B_MN | B_LW;
    step(LAT + 1);
    chk("serve_w_pend", 16'(pending), 16'hd);
    pulse_done();
    chk("after_done_pend", 16'(pending), 16'h8);
    chk("after_done_req", 16'(ped_req), 16'h0);
    step(1);
    chk("rereq_req", 16'(ped_req), 16'h1);
    chk("rereq_dir", 16'(ped_dir), 16'h8);
    pulse_ack();
    pulse_done();
    chk("w_served_pend", 16'(pending), 16'h0);
    btn_in = 4'b0000;
    step(LAT + 2);
    chk("w_served_req", 16'(ped_req), 16'h0);

    // Starvation on Main South
    btn_in = B_MS;
    step(LAT);
    chk("starve_req_early", 16'(ped_req), 16'h0);
    step(1);
    chk("starve_req", 16'(ped_req), 16'h1);
    step(MAXW - 1);
    chk("starve_urgent_early", 16'(urgent), 16'h0);
    step(1);
    chk("starve_urgent", 16'(urgent), 16'h1);
    step(10);
    chk("starve_urgent_hold", 16'(urgent), 16'h1);
    chk("starve_req_hold", 16'(ped_req), 16'h1);
    pulse_ack();
    chk("starve_urgent_clr", 16'(urgent), 16'h0);
    pulse_done();
    btn_in = 4'b0000;
    step(LAT + 2);
    chk("starve_end_pend", 16'(pending), 16'h0);

    // New West edge in the very cycle ack arrives
    btn_in = B_MN;
    step(LAT + 1);
    chk("simul_req", 16'(ped_req), 16'h1);
    btn_in = B_MN | B_LW;
    step(LAT - 1);
    pulse_ack();
    chk("simul_dir", 16'(ped_dir), 16'h9);
    chk("simul_pend", 16'(pending), 16'h9);
    pulse_done();
    chk("simul_done_pend", 16'(pending), 16'h0);
    step(1);
    chk("simul_no_rereq", 16'(ped_req), 16'h0);
    btn_in = 4'b0000;
    step(LAT + 2);

    // Reset in the middle of SERVE
    btn_in = B_MN | B_LE;
    step(LAT + 1);
    pulse_ack();
    chk("mid_serve_pend", 16'(pending), 16'h5);
    chk("mid_serve_dir", 16'(ped_dir), 16'h5);
    rst_a = 1'b1;
    #1;
    chk("async_rst_req", 16'(ped_req), 16'h0);
    chk("async_rst_dir", 16'(ped_dir), 16'h0);
    chk("async_rst_pend", 16'(pending), 16'h0);
    chk("async_rst_urgent", 16'(urgent), 16'h0);
    btn_in = 4'b0000;
    step(3);
    rst_a = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      chk("idle_req", 16'(ped_req), 16'h0);
    end
    chk("idle_pend", 16'(pending), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ped_request_ctrl.md
# ped_request_ctrl

Pedestrian push-button front end for the traffic light controller. It synchronizes and debounces four crosswalk buttons and latches each press as a pending request. It then runs a request/acknowledge/done handshake with the light sequencer, so pedestrian phases are granted on demand rather than on every cycle of the counter. It sits between the board buttons and the pedestrian system, and is instantiated alongside the light and pedestrian controllers in the top level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a level change (range 2..255).
- MAX_WAIT, 64: cycles a request may sit in REQ before `urgent` asserts (range 1..65535).

Ports:
- clk  in  1  system clock.
- rst_a  in  1  reset; asynchronous, active-high.
- btn_in  in  4  raw buttons: [0] Main North, [1] Main South, [2] Local East, [3] Local West.
- ped_req  out  1  request to sequencer; level.
- ped_dir  out  4  directions covered by the current request.
- ped_ack  in  1  one-cycle pulse: sequencer has accepted the request and starts the walk phase.
- ped_done  in  1  one-cycle pulse: walk phase finished.
- pending  out  4  latched, not-yet-served presses.
- urgent  out  1  request has waited at least MAX_WAIT cycles.

## Operation
- Each button goes through a 2-flop synchronizer, then an optional debounce filter, then a rising-edge detector. A detected edge sets the matching `pending` bit.
- FSM states: IDLE, REQ, SERVE.
- IDLE:
  - `ped_req`=0.
  - If `pending`!=0, go to REQ.
  - `ped_ack` and `ped_done` are ignored.
- REQ:
  - `ped_req`=1 and `ped_dir`=`pending`, tracked live so new presses join the request.
  - On `ped_ack`, capture served mask = `pending` | edges detected in the same cycle, then go to SERVE.
  - `ped_done` is ignored.
- SERVE:
  - `ped_req`=0 and `ped_dir` holds the served mask.
  - A press on a served direction is dropped, because that walk is already on.
  - A press on any other direction sets `pending` normally.
  - On `ped_done`, clear the served bits from `pending`, then go to IDLE.
  - If `ped_ack` and `ped_done` arrive in the same cycle, `ped_done` wins.
- Wait counter: 16-bit, counts every cycle in REQ and saturates at MAX_WAIT. `urgent` = (count == MAX_WAIT). The counter clears on entry to SERVE.
- Reset (any state, mid-handshake included):
  - state=IDLE.
  - `pending`=0, `ped_req`=0, `ped_dir`=0, `urgent`=0.
  - Wait counter=0, debounce counters=0, synchronizer and filtered levels=0.
  - A button held through reset release registers as a new press once its filtered level rises.

## Timing
- Raw button rises at cycle 0 and is held stable:
  - synchronizer output is high at cycle 2;
  - with debounce, the filtered level is high at cycle 2+DEBOUNCE_CYCLES and `pending` at cycle 3+DEBOUNCE_CYCLES;
  - without debounce, `pending` is high at cycle 3.
- `ped_req` rises 1 cycle after `pending` becomes nonzero.
- Served `pending` bits clear 1 cycle after `ped_done`, and the FSM is back in IDLE in that same cycle. If `pending` is still nonzero, `ped_req` rises again on the next cycle.
- `urgent` rises on the cycle the count reaches MAX_WAIT and falls 1 cycle after `ped_ack`.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples must not set `pending`.

## Configuration
- `PED_DEBOUNCE_EN` defined: the per-button debounce filter is compiled in. The filtered level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current level; any sample equal to the current level resets the counter.
- `PED_DEBOUNCE_EN` undefined: the filter is removed, the filtered level equals the synchronizer output, and DEBOUNCE_CYCLES is unused.

## Structure
- Shared package `traffic_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVE=2'd2);
  - the direction index constants DIR_MN=0, DIR_MS=1, DIR_LE=2, DIR_LW=3.
- Sub-module `ped_debounce`: one button's synchronizer plus filter, with the filter under the macro. It is instantiated 4 times, and edge detection and the FSM stay in the parent.

## Test plan
- Reset and idle: assert `rst_a` mid-SERVE with `pending`=4'b0101.
  - All outputs go to 0 immediately.
  - After release with no presses, `ped_req` stays 0 for 100 cycles.
- Single press with debounce (DEBOUNCE_CYCLES=16): btn_in[2] high from cycle 0.
  - `pending`=4'b0100 at cycle 19 and `ped_req`=1 at cycle 20.
  - Pulse ack, then done: `pending`=0 one cycle after done.
- Glitch rejection: btn_in[0] high for 10 cycles then low.
  - `pending` stays 0 and `ped_req` stays 0.
- Join and drop:
  - Press N, then press E while in REQ: `ped_dir`=4'b0101.
  - Ack, then press N during SERVE: the N press is dropped.
  - Press W during SERVE: `pending`=4'b1000 after done and `ped_req` re-asserts one cycle later.
- Starvation: MAX_WAIT=64, press S, withhold ack.
  - `urgent`=1 exactly 64 cycles after `ped_req` rises and stays high.
  - Ack: `urgent`=0 one cycle later.
- Simultaneous events: in REQ, pulse `ped_ack` in the same cycle as a new edge on btn W.
  - The served mask includes W and W is not left in `pending` after done.
